axi_lite_rr_master_arbiter: RTL
===============================

Name: axi_lite_rr_master_arbiter

Overview:
Two-requester round-robin arbiter and sequencer that shares one AXI4-Lite master port between two simple req/ack clients (e.g. CPU-side bridge and DMA config engine). Drives the axi_lite_slave register block.
- Issues one single-beat read or write at a time.
- Returns the response code and read data to the granted client with a one-cycle ack pulse.

Parameters:
AXI_DATA_WIDTH, 32, data width of client and AXI buses
AXI_ADDRESS_WIDTH, 4, address width of client and AXI buses
TIMEOUT_CYCLES, 255, watchdog limit per transaction (used only with ARB_TIMEOUT_EN)

Ports:
S_AXI_ACLK  in  1  single clock for all logic
S_AXI_ARESET  in  1  asynchronous, active-high reset
req  in  2  per-client request level; bit i = client i
we  in  2  per-client direction, 1=write 0=read
addr  in  2*AW  client i address in bits [i*AW +: AW]
wdata  in  2*DW  client i write data, packed as addr
wstrb  in  2*DW/8  client i byte strobes, packed as addr
ack  out  2  one-cycle completion pulse to client i
rdata  out  DW  read data for acked client; valid with ack
resp  out  2  AXI response code for acked client; valid with ack
M_AXI_AWADDR/AWVALID/AWREADY  out/out/in  AW/1/1  write address channel
M_AXI_WDATA/WSTRB/WVALID/WREADY  out/out/out/in  DW/DW/8/1/1  write data channel
M_AXI_BRESP/BVALID/BREADY  in/in/out  2/1/1  write response channel
M_AXI_ARADDR/ARVALID/ARREADY  out/out/in  AW/1/1  read address channel
M_AXI_RDATA/RRESP/RVALID/RREADY  in/in/in/out  DW/2/1/1  read data channel

Behaviour:
- Reset (async, active-high): state=IDLE; all VALID/READY outputs 0; ack=0; rdata=0; resp=0; last_grant=1, so client 0 wins first.
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - Only one request: grant that client.
  - Both requesting: grant the client != last_grant.
  - On grant: latch we/addr/wdata/wstrb of the winner into holding registers; update last_grant.
  - Next state is WR (AWVALID=WVALID=1) or RD_ADDR (ARVALID=1), registered; first VALID appears one cycle after req is sampled.
- WR:
  - AWVALID drops the cycle after AWREADY&&AWVALID; WVALID drops the cycle after WREADY&&WVALID.
  - Handshakes may complete in either order or together.
  - Go to WR_RESP once both are done, with BREADY=1.
- WR_RESP: on BVALID&&BREADY, capture BRESP into resp, drop BREADY, go to DONE.
- RD_ADDR: hold ARVALID/ARADDR until ARREADY; then ARVALID=0, RREADY=1, go to RD_DATA.
- RD_DATA: on RVALID&&RREADY, capture RDATA/RRESP, drop RREADY, go to DONE.
- DONE: ack[grant]=1 for exactly this cycle, rdata/resp stable; req ignored; go to IDLE.
  - Write acks drive rdata=0.
- Client rules:
  - Client holds req and its payload until ack. Payload is latched, so later changes are don't-care.
  - A client keeping req high after ack issues a new transaction.
- Fairness: with both clients requesting continuously, grants strictly alternate 0,1,0,1.
- VALID signals never drop before their handshake (AXI rule). No combinational path from M_AXI inputs to M_AXI outputs.
- Minimum write latency: req → ack = 4 cycles with an always-ready slave (IDLE, WR, WR_RESP, DONE). Minimum read latency is also 4.
- Reset mid-transaction: everything returns to reset values immediately; no ack is generated for the aborted transaction.

Optional Feature:
ARB_TIMEOUT_EN:
- Defined:
  - Cycle counter cleared on grant; increments in WR, WR_RESP, RD_ADDR, RD_DATA.
  - When it reaches TIMEOUT_CYCLES: deassert all M_AXI VALID/READY, go to DONE with resp=2'b11 and rdata=0.
  - Sticky output timeout_err (1 bit) is set and cleared only by reset.
- Undefined: no counter and no timeout_err port; the arbiter waits indefinitely.

Test Plan:
- Client 0 writes addr=4, wdata=0xDEADBEEF, wstrb=0xF; slave always ready → AW/W valid in cycle 1, ack[0] in cycle 3 after req (4-cycle latency), resp=00.
- Client 1 reads addr=4 after that write → ack[1] pulse, rdata=0xDEADBEEF, resp=00.
- Both req held high for 6 transactions → grant order 0,1,0,1,0,1; never two acks in the same cycle.
- AWREADY delayed 3 cycles, WREADY immediate → WVALID drops after 1 cycle, AWVALID holds 3 cycles, single ack, resp=00.
- RVALID delayed 5 cycles, RRESP=10 → RREADY held until handshake, ack with resp=10.
- ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, BVALID never asserted → ack after 8 counting cycles, resp=11, timeout_err=1; reset asserted mid-read → all outputs 0 asynchronously, no ack.

Source files
------------

// File: rtl/axi_lite_rr_master_arbiter.sv
// Two-client round-robin arbiter that serialises single-beat AXI4-Lite reads/writes onto one master port.
// Optional ARB_TIMEOUT_EN adds a per-transaction watchdog and a sticky timeout_err output.
module axi_lite_rr_master_arbiter #(
    parameter int AXI_DATA_WIDTH    = 32,
    parameter int AXI_ADDRESS_WIDTH = 4,
    parameter int TIMEOUT_CYCLES    = 255
) (
    input  logic                                S_AXI_ACLK,
    input  logic                                S_AXI_ARESET,
    input  logic [1:0]                          req,
    input  logic [1:0]                          we,
    input  logic [2*AXI_ADDRESS_WIDTH-1:0]      addr,
    input  logic [2*AXI_DATA_WIDTH-1:0]         wdata,
    input  logic [2*(AXI_DATA_WIDTH/8)-1:0]     wstrb,
    output logic [1:0]                          ack,
    output logic [AXI_DATA_WIDTH-1:0]           rdata,
    output logic [1:0]                          resp,
`ifdef ARB_TIMEOUT_EN
    output logic                                timeout_err,
`endif
    output logic [AXI_ADDRESS_WIDTH-1:0]        M_AXI_AWADDR,
    output logic                                M_AXI_AWVALID,
    input  logic                                M_AXI_AWREADY,
    output logic [AXI_DATA_WIDTH-1:0]           M_AXI_WDATA,
    output logic [AXI_DATA_WIDTH/8-1:0]         M_AXI_WSTRB,
    output logic                                M_AXI_WVALID,
    input  logic                                M_AXI_WREADY,
    input  logic [1:0]                          M_AXI_BRESP,
    input  logic                                M_AXI_BVALID,
    output logic                                M_AXI_BREADY,
    output logic [AXI_ADDRESS_WIDTH-1:0]        M_AXI_ARADDR,
    output logic                                M_AXI_ARVALID,
    input  logic                                M_AXI_ARREADY,
    input  logic [AXI_DATA_WIDTH-1:0]           M_AXI_RDATA,
    input  logic [1:0]                          M_AXI_RRESP,
    input  logic                                M_AXI_RVALID,
    output logic                                M_AXI_RREADY
);

    localparam int DW = AXI_DATA_WIDTH;
    localparam int AW = AXI_ADDRESS_WIDTH;
    localparam int SW = AXI_DATA_WIDTH / 8;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR      = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_ADDR = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;

    logic [2:0]    state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic          bready_q, bready_d;
    logic          arvalid_q, arvalid_d;
    logic          rready_q, rready_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    resp_q, resp_d;
    logic          winner;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        rdata_d      = rdata_q;
        resp_d       = resp_q;
        winner       = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_err_d = timeout_err_q;
`endif

        case (state_q)
            IDLE: begin
                // With both clients requesting, the one not served last time wins
                winner = (req == 2'b11) ? ~last_grant_q : req[1];
                if (|req) begin
                    last_grant_d = winner;
                    addr_d       = addr[(winner ? AW : 0) +: AW];
                    wdata_d      = wdata[(winner ? DW : 0) +: DW];
                    wstrb_d      = wstrb[(winner ? SW : 0) +: SW];
`ifdef ARB_TIMEOUT_EN
                    cnt_d        = '0;
`endif
                    if (we[winner]) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RD_ADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                awvalid_d = awvalid_q & ~M_AXI_AWREADY;
                wvalid_d  = wvalid_q & ~M_AXI_WREADY;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (M_AXI_BVALID && bready_q) begin
                    resp_d   = M_AXI_BRESP;
                    rdata_d  = '0;
                    bready_d = 1'b0;
                    state_d  = DONE;
                end
            end
            RD_ADDR: begin
                if (M_AXI_ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (M_AXI_RVALID && rready_q) begin
                    rdata_d  = M_AXI_RDATA;
                    resp_d   = M_AXI_RRESP;
                    rready_d = 1'b0;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

`ifdef ARB_TIMEOUT_EN
        // Watchdog overrides whatever the bus did this cycle
        if (state_q inside {WR, WR_RESP, RD_ADDR, RD_DATA}) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
                awvalid_d     = 1'b0;
                wvalid_d      = 1'b0;
                bready_d      = 1'b0;
                arvalid_d     = 1'b0;
                rready_d      = 1'b0;
                resp_d        = 2'b11;
                rdata_d       = '0;
                timeout_err_d = 1'b1;
                state_d       = DONE;
            end
        end
`endif
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            rdata_q      <= '0;
            resp_q       <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            rdata_q      <= rdata_d;
            resp_q       <= resp_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    // last_grant_q doubles as the current grant once a transaction is under way
    assign ack           = (state_q == DONE) ? {last_grant_q, ~last_grant_q} : 2'b00;
    assign rdata         = rdata_q;
    assign resp          = resp_q;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWVALID = awvalid_q;
    assign M_AXI_WDATA   = wdata_q;
    assign M_AXI_WSTRB   = wstrb_q;
    assign M_AXI_WVALID  = wvalid_q;
    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout_err   = timeout_err_q;
`endif

endmodule
